// File: rtl/systolic_mm_pkg.sv
// Shared opcodes, command-word field positions and FSM state type for the
// systolic matrix-multiply accelerator.
`timescale 1ns/1ps
package systolic_mm_pkg;

    localparam logic [3:0] OP_LOAD_A = 4'h1;
    localparam logic [3:0] OP_LOAD_B = 4'h2;
    localparam logic [3:0] OP_START  = 4'h3;
    localparam logic [3:0] OP_SELECT = 4'h4;
    localparam logic [3:0] OP_CLEAR  = 4'h5;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int COL_MSB = 15;
    localparam int COL_LSB = 12;
    localparam int ROW_MSB = 11;
    localparam int ROW_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registers a/b onward (right/down) and accumulates
// their signed product into a local accumulator.
`timescale 1ns/1ps
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     clear,
    input  logic                     en,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [2*DATA_W-1:0] prod;

    assign prod = a_in * b_in;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clear) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm.sv
// Memory-mapped output-stationary N x N systolic multiplier C = A x B,
// driven by 32-bit command writes and read back through one status/result word.
`timescale 1ns/1ps
module systolic_mm
    import systolic_mm_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(3 * N - 2);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               ptr_row_q, ptr_row_d, ptr_col_q, ptr_col_d;
    logic signed [DATA_W-1:0] a_q [N][N];
    logic signed [DATA_W-1:0] a_d [N][N];
    logic signed [DATA_W-1:0] b_q [N][N];
    logic signed [DATA_W-1:0] b_d [N][N];

    logic [3:0]               op, row_f, col_f;
    logic signed [DATA_W-1:0] data_f;
    logic                     cmd_ok, idx_ok, is_load_a, is_load_b, is_start, is_select, is_clear;
    logic                     pe_clear, pe_en;

    assign op        = wdata[OP_MSB:OP_LSB];
    assign row_f     = wdata[ROW_MSB:ROW_LSB];
    assign col_f     = wdata[COL_MSB:COL_LSB];
    assign data_f    = wdata[DATA_W-1:0];
    assign cmd_ok    = (wen == 4'b1111);
    assign idx_ok    = (row_f < 4'(N)) && (col_f < 4'(N));
    assign is_load_a = cmd_ok && (op == OP_LOAD_A) && idx_ok;
    assign is_load_b = cmd_ok && (op == OP_LOAD_B) && idx_ok;
    assign is_start  = cmd_ok && (op == OP_START);
    assign is_select = cmd_ok && (op == OP_SELECT) && idx_ok;
    assign is_clear  = cmd_ok && (op == OP_CLEAR);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pe_clear = is_clear;
        unique case (state_q)
            IDLE, DONE: begin
                if (is_start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    pe_clear = 1'b1;
                end else if (state_q == DONE && (is_load_a || is_load_b || is_clear)) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_clear) begin
                    state_d = IDLE;
                end else if (cnt_q == RUN_LAST) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand files are frozen while the array is consuming them.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        ptr_row_d = ptr_row_q;
        ptr_col_d = ptr_col_q;
        if (is_clear) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_d[i][k] = '0;
                    b_d[i][k] = '0;
                end
            end
            ptr_row_d = '0;
            ptr_col_d = '0;
        end else begin
            if (state_q != RUN) begin
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < N; k++) begin
                        if (row_f == 4'(i) && col_f == 4'(k)) begin
                            if (is_load_a) a_d[i][k] = data_f;
                            if (is_load_b) b_d[i][k] = data_f;
                        end
                    end
                end
            end
            if (is_select) begin
                ptr_row_d = row_f[1:0];
                ptr_col_d = col_f[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_row_q <= '0;
            ptr_col_q <= '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_q[i][k] <= '0;
                    b_q[i][k] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_row_q <= ptr_row_d;
            ptr_col_q <= ptr_col_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    // Skewed feed: row i sees A[i][k] at cycle i+k, column j sees B[k][j] at j+k.
    logic signed [DATA_W-1:0] a_feed [N];
    logic signed [DATA_W-1:0] b_feed [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (state_q == RUN && cnt_q == CNT_W'(i + k)) begin
                    a_feed[i] = a_q[i][k];
                    b_feed[i] = b_q[k][i];
                end
            end
        end
    end

    assign pe_en = (state_q == RUN);

    logic signed [DATA_W-1:0] a_h [N][N+1];
    logic signed [DATA_W-1:0] b_v [N+1][N];
    logic signed [ACC_W-1:0]  c_acc [N][N];
    logic [N-1:0]             unused_edge;
    logic                     unused_cmd;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            assign a_h[gi][0]      = a_feed[gi];
            assign b_v[0][gi]      = b_feed[gi];
            assign unused_edge[gi] = ^{a_h[gi][N], b_v[N][gi]};
            for (gj = 0; gj < N; gj++) begin : g_col
                systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                    .clk    (clk),
                    .resetn (resetn),
                    .a_in   (a_h[gi][gj]),
                    .b_in   (b_v[gi][gj]),
                    .clear  (pe_clear),
                    .en     (pe_en),
                    .a_out  (a_h[gi][gj+1]),
                    .b_out  (b_v[gi+1][gj]),
                    .acc    (c_acc[gi][gj])
                );
            end
        end
    endgenerate

    assign unused_cmd = ^{wdata[27:16], unused_edge};

    logic signed [ACC_W-1:0] c_sel;
    logic                    busy, done;

    always_comb begin
        c_sel = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (ptr_row_q == 2'(i) && ptr_col_q == 2'(k)) c_sel = c_acc[i][k];
            end
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign rdata = {busy, done, busy ? 30'd0 : {{(30 - ACC_W){c_sel[ACC_W-1]}}, c_sel}};

endmodule

// File: tb/tb_systolic_mm.sv
// Directed bench for systolic_mm (N=2): loads, runs, reads back C and checks
// busy length, ignored commands, CLEAR and asynchronous reset.
`timescale 1ns/1ps
module tb_systolic_mm;
    import systolic_mm_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  wen = 4'b0000;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [31:0] v;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    systolic_mm #(.N(2), .DATA_W(8), .ACC_W(20)) dut (
        .clk    (clk),
        .resetn (resetn),
        .wen    (wen),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    function automatic logic [31:0] cmd(logic [3:0] op, int r, int c, int d);
        return {op, 12'h000, 4'(c), 4'(r), 8'(d)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(logic [3:0] w, logic [31:0] d);
        wen   = w;
        wdata = d;
        @(posedge clk);
        #1;
        wen   = 4'b0000;
        wdata = 32'h0;
    endtask

    task automatic wait_busy(input int start_cnt, output int cnt);
        cnt = start_cnt;
        while (rdata[31] && cnt < 20) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(output int cnt);
        wr(4'hF, cmd(OP_START, 0, 0, 0));
        wait_busy(0, cnt);
    endtask

    task automatic rd(int r, int c, output logic [31:0] val);
        wr(4'hF, cmd(OP_SELECT, r, c, 0));
        val = rdata;
    endtask

    task automatic load(int a00, int a01, int a10, int a11, int b00, int b01, int b10, int b11);
        wr(4'hF, cmd(OP_LOAD_A, 0, 0, a00));
        wr(4'hF, cmd(OP_LOAD_A, 0, 1, a01));
        wr(4'hF, cmd(OP_LOAD_A, 1, 0, a10));
        wr(4'hF, cmd(OP_LOAD_A, 1, 1, a11));
        wr(4'hF, cmd(OP_LOAD_B, 0, 0, b00));
        wr(4'hF, cmd(OP_LOAD_B, 0, 1, b01));
        wr(4'hF, cmd(OP_LOAD_B, 1, 0, b10));
        wr(4'hF, cmd(OP_LOAD_B, 1, 1, b11));
    endtask

    initial begin
        // Power-on reset.
        #1;
        chk("reset_rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_rdata", rdata, 32'h0);

        // Basic 2x2.
        load(1, 2, 3, 4, 5, 6, 7, 8);
        run(n);
        chk("basic_busy_len", 32'(n), 32'd5);
        chk("basic_done", {31'b0, rdata[30]}, 32'd1);
        rd(0, 0, v); chk("basic_c00", v, 32'h4000_0013);
        rd(0, 1, v); chk("basic_c01", v, 32'h4000_0016);
        rd(1, 0, v); chk("basic_c10", v, 32'h4000_002B);
        rd(1, 1, v); chk("basic_c11", v, 32'h4000_0032);

        // Out-of-range SELECT keeps the pointer on (1,1).
        rd(2, 0, v); chk("oor_select", v, 32'h4000_0032);

        // Out-of-range LOAD_B and partial-strobe LOAD_A are ignored.
        wr(4'hF, cmd(OP_LOAD_B, 3, 0, 99));
        wr(4'b0001, cmd(OP_LOAD_A, 0, 0, 100));
        run(n);
        chk("ign_busy_len", 32'(n), 32'd5);
        rd(0, 0, v); chk("ign_c00", v, 32'h4000_0013);
        rd(1, 0, v); chk("ign_c10", v, 32'h4000_002B);

        // LOAD_A and START during RUN are ignored.
        wr(4'hF, cmd(OP_START, 0, 0, 0));
        wr(4'hF, cmd(OP_LOAD_A, 0, 0, 9));
        wr(4'hF, cmd(OP_START, 0, 0, 0));
        wait_busy(2, n);
        chk("run_ign_busy_len", 32'(n), 32'd5);
        rd(0, 0, v); chk("run_ign_c00", v, 32'h4000_0013);
        rd(1, 1, v); chk("run_ign_c11", v, 32'h4000_0032);

        // Signed operands; a LOAD leaves DONE.
        wr(4'hF, cmd(OP_LOAD_A, 0, 0, -1));
        chk("done_clr_by_load", {31'b0, rdata[30]}, 32'd0);
        load(-1, 0, 0, -1, 5, 6, 7, 8);
        run(n);
        rd(0, 0, v); chk("signed_c00_low", {2'b00, v[29:0]}, 32'h3FFF_FFFB);
        rd(1, 1, v); chk("signed_c11", v, 32'h7FFF_FFF8);

        load(-128, -128, 0, 0, -128, 6, -128, 8);
        run(n);
        rd(0, 0, v); chk("big_c00", v, 32'h4000_8000);
        rd(0, 1, v); chk("big_c01", v, 32'h7FFF_F900);
        rd(1, 0, v); chk("big_c10", v, 32'h4000_0000);

        // CLEAR mid-run, then a START on cleared operands.
        wr(4'hF, cmd(OP_START, 0, 0, 0));
        wr(4'hF, cmd(OP_CLEAR, 0, 0, 0));
        chk("clear_mid_run", rdata, 32'h0);
        run(n);
        chk("clear_busy_len", 32'(n), 32'd5);
        rd(0, 0, v); chk("clear_c00", v, 32'h4000_0000);
        rd(0, 1, v); chk("clear_c01", v, 32'h4000_0000);
        rd(1, 0, v); chk("clear_c10", v, 32'h4000_0000);
        rd(1, 1, v); chk("clear_c11", v, 32'h4000_0000);

        // Asynchronous reset mid-run.
        load(3, 0, 0, 0, 4, 0, 0, 0);
        wr(4'hF, cmd(OP_START, 0, 0, 0));
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_rdata", rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_release_rdata", rdata, 32'h0);
        run(n);
        rd(0, 0, v); chk("reset_cleared_a", v, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
